alu_exec_unit: RTL and testbench

Execute-stage arithmetic block for the single-cycle MIPS datapath.
- Decodes the 2-bit main-control ALU op plus the R-type funct field into a 4-bit ALU control code.
- Performs the 32-bit ALU operation and registers the result, zero and overflow flags.
- Computes PC+4 and the branch target with two combinational adders.

---
 rtl/alu_exec_unit.sv | 148 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage arithmetic block for the single-cycle MIPS datapath.
//   - Decodes alu_op_i and funct_i into a 4-bit ALU control code (combinational).
//   - Runs the 32-bit ALU and registers the result, zero and signed-overflow flags.
//   - Computes pc+PC_INC and the branch target with two combinational adders.
// Optional feature: define ALU_SHIFT_EN to build SLL/SRL/SRA. When it is undefined,
// the shift funct codes decode as invalid (1111), give result 0, and shamt_i is ignored.
// Ports:
//   clk_i, reset_i (async, active high)
//   alu_op_i[1:0], funct_i[5:0], src_a_i, src_b_i, shamt_i[4:0], pc_i, imm_ext_i
//   alu_ctrl_o[3:0] (comb), alu_result_o/zero_o/overflow_o (registered),
//   pc_plus4_o, branch_target_o (comb)
module alu_exec_unit #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] PC_INC = 32'h0000_0004
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic [4:0]        shamt_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] imm_ext_i,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] branch_target_o
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_ADDU = 4'b0100;
  localparam logic [3:0] C_SUBU = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1010;
  localparam logic [3:0] C_SLTU = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_INV  = 4'b1111;

  logic [3:0]        ctrl;
  logic [DATA_W-1:0] sum, diff;
  logic [DATA_W-1:0] result_d, result_q;
  logic              ovf_d, ovf_q, zero_q;

  // ---------------- decode ----------------
  always_comb begin
    ctrl = C_INV;
    case (alu_op_i)
      2'b00: ctrl = C_ADD;
      2'b01: ctrl = C_SUB;
      2'b11: ctrl = C_OR;
      default: begin
        case (funct_i)
          6'b100000: ctrl = C_ADD;
          6'b100001: ctrl = C_ADDU;
          6'b100010: ctrl = C_SUB;
          6'b100011: ctrl = C_SUBU;
          6'b100100: ctrl = C_AND;
          6'b100101: ctrl = C_OR;
          6'b100110: ctrl = C_XOR;
          6'b100111: ctrl = C_NOR;
          6'b101010: ctrl = C_SLT;
          6'b101011: ctrl = C_SLTU;
`ifdef ALU_SHIFT_EN
          6'b000000: ctrl = C_SLL;
          6'b000010: ctrl = C_SRL;
          6'b000011: ctrl = C_SRA;
`endif
          default:   ctrl = C_INV;
        endcase
      end
    endcase
  end

  assign alu_ctrl_o = ctrl;

  // ---------------- execute ----------------
  assign sum  = src_a_i + src_b_i;
  assign diff = src_a_i - src_b_i;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (ctrl)
      C_ADD: begin
        result_d = sum;
        // same-sign operands whose sum flips sign
        ovf_d = (src_a_i[DATA_W-1] == src_b_i[DATA_W-1]) &&
                (sum[DATA_W-1] != src_a_i[DATA_W-1]);
      end
      C_ADDU: result_d = sum;
      C_SUB: begin
        result_d = diff;
        // opposite-sign operands whose difference departs from a's sign
        ovf_d = (src_a_i[DATA_W-1] != src_b_i[DATA_W-1]) &&
                (diff[DATA_W-1] != src_a_i[DATA_W-1]);
      end
      C_SUBU: result_d = diff;
      C_AND:  result_d = src_a_i & src_b_i;
      C_OR:   result_d = src_a_i | src_b_i;
      C_XOR:  result_d = src_a_i ^ src_b_i;
      C_NOR:  result_d = ~(src_a_i | src_b_i);
      C_SLT:  result_d = {{(DATA_W-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      C_SLTU: result_d = {{(DATA_W-1){1'b0}}, (src_a_i < src_b_i)};
`ifdef ALU_SHIFT_EN
      C_SLL:  result_d = src_b_i << shamt_i;
      C_SRL:  result_d = src_b_i >> shamt_i;
      C_SRA:  result_d = $signed(src_b_i) >>> shamt_i;
`endif
      default: result_d = '0;
    endcase
  end

`ifndef ALU_SHIFT_EN
  // shamt only feeds the shifter; keep it visibly sunk when the shifter is absent
  logic unused_shamt;
  assign unused_shamt = ^shamt_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  assign alu_result_o = result_q;
  assign zero_o       = zero_q;
  assign overflow_o   = ovf_q;

  // ---------------- PC adders (wrap, no carry out) ----------------
  assign pc_plus4_o      = pc_i + PC_INC;
  assign branch_target_o = pc_plus4_o + (imm_ext_i << 2);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, pc, imm_ext;
  logic [4:0]  shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, pc_plus4, branch_target;
  logic        zero, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] pc4;
    logic [31:0] bt;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk_i(clk), .reset_i(reset), .alu_op_i(alu_op), .funct_i(funct),
    .src_a_i(src_a), .src_b_i(src_b), .shamt_i(shamt), .pc_i(pc),
    .imm_ext_i(imm_ext), .alu_ctrl_o(alu_ctrl), .alu_result_o(alu_result),
    .zero_o(zero), .overflow_o(overflow), .pc_plus4_o(pc_plus4),
    .branch_target_o(branch_target)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operation picked by name from the instruction tables, result
  // computed with wide signed arithmetic so overflow is a range test.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [31:0] p,
                                 input logic [31:0] imm);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ctrl = 4'hF;
    e.res  = 32'h0;
    e.ov   = 1'b0;
    if (op == 2'b00) e.ctrl = 4'h2;
    else if (op == 2'b01) e.ctrl = 4'h6;
    else if (op == 2'b11) e.ctrl = 4'h1;
    else begin
      case (f)
        6'h20: e.ctrl = 4'h2;  6'h21: e.ctrl = 4'h4;
        6'h22: e.ctrl = 4'h6;  6'h23: e.ctrl = 4'h5;
        6'h24: e.ctrl = 4'h0;  6'h25: e.ctrl = 4'h1;
        6'h26: e.ctrl = 4'h3;  6'h27: e.ctrl = 4'hC;
        6'h2A: e.ctrl = 4'h7;  6'h2B: e.ctrl = 4'hB;
`ifdef ALU_SHIFT_EN
        6'h00: e.ctrl = 4'h8;  6'h02: e.ctrl = 4'h9;  6'h03: e.ctrl = 4'hA;
`endif
        default: e.ctrl = 4'hF;
      endcase
    end
    case (e.ctrl)
      4'h2: begin r = sa + sb; e.res = r[31:0];
              e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'h6: begin r = sa - sb; e.res = r[31:0];
              e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'h4: e.res = a + b;
      4'h5: e.res = a - b;
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h3: e.res = a ^ b;
      4'hC: e.res = ~(a | b);
      4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'hB: e.res = (a < b) ? 32'd1 : 32'd0;
      4'h8: e.res = 32'(longint'(b) * (longint'(1) << sh));
      4'h9: e.res = 32'(longint'(b) / (longint'(1) << sh));
      4'hA: begin r = sb; for (int k = 0; k < int'(sh); k++) r = (r - (r & 1)) / 2;
              e.res = r[31:0]; end
      default: e.res = 32'h0;
    endcase
    e.z   = (e.res == 32'h0);
    e.pc4 = p + 32'd4;
    e.bt  = e.pc4 + 32'(imm * 4);
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] p, input logic [31:0] imm);
    @(negedge clk);
    reset  = 1'b0;
    alu_op = op; funct = f; src_a = a; src_b = b; shamt = sh; pc = p; imm_ext = imm;
    sb_q.push_back(model(op, f, a, b, sh, p, imm));
  endtask

  task automatic drain();
    int budget = 10;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every edge, compare the registered outputs (and the combinational
  // outputs of the still-held inputs) against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("alu_ctrl",      {28'h0, alu_ctrl}, {28'h0, e.ctrl});
        chk("alu_result",    alu_result,        e.res);
        chk("zero",          {31'h0, zero},     {31'h0, e.z});
        chk("overflow",      {31'h0, overflow}, {31'h0, e.ov});
        chk("pc_plus4",      pc_plus4,          e.pc4);
        chk("branch_target", branch_target,     e.bt);
      end
    end
  end

  logic [5:0] fl [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F, 6'h01, 6'h2C};
  logic [31:0] cv [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                          32'h80000000, 32'h80000001, 32'hF0F0F0F0, 32'h0FF00FF0};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return cv[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    // reset with live inputs: registered outputs forced, async
    reset = 1'b1; alu_op = 2'b00; funct = 6'h20; src_a = 32'd5; src_b = 32'd3;
    shamt = 5'd0; pc = 32'h00400000; imm_ext = 32'hFFFFFFFF;
    #1;
    chk("rst_result", alu_result, 32'h0);
    chk("rst_zero",   {31'h0, zero}, 32'h1);
    chk("rst_ovf",    {31'h0, overflow}, 32'h0);
    chk("rst_pc4",    pc_plus4, 32'h00400004);
    chk("rst_bt",     branch_target, 32'h00400000);
    @(posedge clk); #1;
    chk("rst_hold_result", alu_result, 32'h0);
    chk("rst_hold_zero",   {31'h0, zero}, 32'h1);

    // release: first edge captures 5+3
    issue(2'b00, 6'h20, 32'd5, 32'd3, 5'd0, 32'h00400000, 32'hFFFFFFFF);
    issue(2'b10, 6'h22, 32'd7, 32'd7, 5'd0, 32'hFFFFFFFC, 32'h0);
    issue(2'b01, 6'h00, 32'd3, 32'd5, 5'd0, 32'h0, 32'h1);
    issue(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h100, 32'h80000000);
    issue(2'b10, 6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h100, 32'h3);
    issue(2'b10, 6'h22, 32'h80000000, 32'h1, 5'd0, 32'h100, 32'h3);
    issue(2'b01, 6'h00, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h23, 32'h80000000, 32'h1, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h2A, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0, 32'h0);
    issue(2'b11, 6'h3F, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0, 32'h0);
    issue(2'b10, 6'h00, 32'h0, 32'h80000001, 5'd4, 32'h0, 32'h0);
    issue(2'b10, 6'h02, 32'h0, 32'h80000001, 5'd4, 32'h0, 32'h0);
    issue(2'b10, 6'h03, 32'h0, 32'h80000001, 5'd4, 32'h0, 32'h0);
    issue(2'b10, 6'h03, 32'h0, 32'h40000000, 5'd31, 32'h0, 32'h0);
    issue(2'b10, 6'h3F, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h0, 32'h0);
    drain();

    // async reset in the middle of a cycle, then restart on live inputs
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_result", alu_result, 32'h0);
    chk("midrst_zero",   {31'h0, zero}, 32'h1);
    chk("midrst_ovf",    {31'h0, overflow}, 32'h0);
    issue(2'b00, 6'h00, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 32'h00400000, 32'hFFFFFFFF);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 15)];
      issue(2'($urandom), f, pick(), pick(), 5'($urandom), pick(), pick());
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
